// File: rtl/astar_pkg.sv
// rtl/astar_pkg.sv - shared A* pathfinder types, FSM states and default sizes
package astar_pkg;

    localparam int DEF_COORD_W = 8;
    localparam int DEF_DEPTH   = 400;

    typedef logic [DEF_COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        CL_IDLE = 2'd0,
        CL_SCAN = 2'd1,
        CL_RESP = 2'd2
    } cl_state_t;

endpackage

// File: rtl/closed_list_ram.sv
// rtl/closed_list_ram.sv - closed-list storage, one sync write port, one async read port
module closed_list_ram #(
    parameter int DEPTH  = 400,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
) (
    input  logic              Clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Combinational read lets the scan compare one entry per clock.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/closed_list_search.sv
// rtl/closed_list_search.sv - closed-list append store with linear hit/index search
module closed_list_search
    import astar_pkg::*;
#(
    parameter  int COORD_W = DEF_COORD_W,
    parameter  int DEPTH   = DEF_DEPTH,
    localparam int IDX_W   = $clog2(DEPTH + 1)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               clear,
    input  logic               ins_valid,
    input  logic [COORD_W-1:0] ins_x,
    input  logic [COORD_W-1:0] ins_y,
    output logic               ins_ready,
    input  logic               req_valid,
    input  logic [COORD_W-1:0] req_x,
    input  logic [COORD_W-1:0] req_y,
    output logic               req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_found,
    output logic [IDX_W-1:0]   rsp_index,
    output logic [IDX_W-1:0]   count,
    output logic               full,
    output logic               busy
);

    localparam int ADDR_W = $clog2(DEPTH);

    cl_state_t              state, state_d;
    logic [IDX_W-1:0]       idx;
    logic [COORD_W-1:0]     key_x, key_y;
    logic [2*COORD_W-1:0]   rd_data;
    logic                   ins_fire, req_fire, hit, last;

    closed_list_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (2 * COORD_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .Clk     (Clk),
        .wr_en   (ins_fire && !clear),
        .wr_addr (count[ADDR_W-1:0]),
        .wr_data ({ins_x, ins_y}),
        .rd_addr (idx[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    assign full      = (count == IDX_W'(DEPTH));
    assign busy      = (state != CL_IDLE);
    assign rsp_valid = (state == CL_RESP);
    assign ins_ready = (state == CL_IDLE) && !full;
    // Appends win over searches so a search always sees the newest node.
    assign req_ready = (state == CL_IDLE) && !ins_valid;
    assign ins_fire  = ins_valid && ins_ready;
    assign req_fire  = req_valid && req_ready;
    assign hit       = (rd_data == {key_x, key_y});
    assign last      = (idx == count - IDX_W'(1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= CL_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            CL_IDLE: if (req_fire) state_d = (count == '0) ? CL_RESP : CL_SCAN;
            CL_SCAN: if (hit || last) state_d = CL_RESP;
            CL_RESP: if (rsp_ready) state_d = CL_IDLE;
            default: state_d = CL_IDLE;
        endcase
        if (clear) state_d = CL_IDLE;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count     <= '0;
            idx       <= '0;
            key_x     <= '0;
            key_y     <= '0;
            rsp_found <= 1'b0;
            rsp_index <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            if (ins_fire) count <= count + IDX_W'(1);
            if (req_fire) begin
                key_x <= req_x;
                key_y <= req_y;
                idx   <= '0;
                if (count == '0) begin
                    rsp_found <= 1'b0;
                    rsp_index <= '0;
                end
            end
            if (state == CL_SCAN) begin
                if (hit) begin
                    rsp_found <= 1'b1;
                    rsp_index <= idx;
                end else if (last) begin
                    rsp_found <= 1'b0;
                    rsp_index <= '0;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_closed_list_search.sv
// tb/tb_closed_list_search.sv - table-driven bench for closed_list_search
module tb_closed_list_search;

    localparam int COORD_W = 8;
    localparam int DEPTH   = 6;
    localparam int IDX_W   = $clog2(DEPTH + 1);

    logic               Clk = 1'b0;
    logic               Reset = 1'b1;
    logic               clear = 1'b0;
    logic               ins_valid = 1'b0;
    logic [COORD_W-1:0] ins_x = '0, ins_y = '0;
    logic               ins_ready;
    logic               req_valid = 1'b0;
    logic [COORD_W-1:0] req_x = '0, req_y = '0;
    logic               req_ready;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic               rsp_found;
    logic [IDX_W-1:0]   rsp_index;
    logic [IDX_W-1:0]   count;
    logic               full;
    logic               busy;

    int n_vec = 0;
    int n_err = 0;

    closed_list_search #(.COORD_W(COORD_W), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .clear(clear),
        .ins_valid(ins_valid), .ins_x(ins_x), .ins_y(ins_y), .ins_ready(ins_ready),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_found(rsp_found),
        .rsp_index(rsp_index), .count(count), .full(full), .busy(busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit       is_search;
        bit [7:0] x;
        bit [7:0] y;
        bit       exp_ready;
        bit       exp_found;
        int       exp_index;
        int       exp_lat;
        int       exp_count;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk_app(bit [7:0] x, bit [7:0] y, bit rdy, int cnt);
        vec_t v = '{0, x, y, rdy, 1'b0, 0, 0, cnt};
        return v;
    endfunction

    function automatic vec_t mk_srch(bit [7:0] x, bit [7:0] y, bit f, int i, int l, int cnt);
        vec_t v = '{1, x, y, 1'b1, f, i, l, cnt};
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_append(input bit [7:0] x, input bit [7:0] y, input bit exp_rdy);
        ins_valid = 1'b1; ins_x = x; ins_y = y;
        #1;
        chk("ins_ready", int'(ins_ready), int'(exp_rdy));
        @(posedge Clk); #1;
        ins_valid = 1'b0;
    endtask

    task automatic do_search(input bit [7:0] x, input bit [7:0] y, input bit ef,
                             input int ei, input int el, input int hold);
        int edges;
        int cnt0;
        req_valid = 1'b1; req_x = x; req_y = y;
        #1;
        chk("req_ready", int'(req_ready), 1);
        @(posedge Clk); #1;
        req_valid = 1'b0;
        edges = 0;
        do begin
            @(posedge Clk); #1;
            edges++;
        end while (!rsp_valid && edges < 50);
        chk("latency", edges, el);
        chk("rsp_found", int'(rsp_found), int'(ef));
        chk("rsp_index", int'(rsp_index), ei);
        cnt0 = int'(count);
        if (hold > 0) begin
            ins_valid = 1'b1; ins_x = 8'h55; ins_y = 8'h55;
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge Clk); #1;
            chk("hold_valid", int'(rsp_valid), 1);
            chk("hold_found", int'(rsp_found), int'(ef));
            chk("hold_index", int'(rsp_index), ei);
            chk("hold_ins_ready", int'(ins_ready), 0);
        end
        ins_valid = 1'b0;
        if (hold > 0) chk("hold_count", int'(count), cnt0);
        rsp_ready = 1'b1;
        @(posedge Clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", int'(rsp_valid), 0);
        chk("busy_drop", int'(busy), 0);
    endtask

    initial begin
        tbl.push_back(mk_srch(3, 4, 0, 0, 1, 0));
        tbl.push_back(mk_app(1, 1, 1, 1));
        tbl.push_back(mk_app(2, 5, 1, 2));
        tbl.push_back(mk_app(7, 9, 1, 3));
        tbl.push_back(mk_srch(7, 9, 1, 2, 3, 3));
        tbl.push_back(mk_app(2, 5, 1, 4));
        tbl.push_back(mk_srch(2, 5, 1, 1, 2, 4));
        tbl.push_back(mk_srch(9, 9, 0, 0, 4, 4));
        tbl.push_back(mk_srch(1, 1, 1, 0, 1, 4));
        tbl.push_back(mk_app(4, 4, 1, 5));
        tbl.push_back(mk_app(5, 6, 1, 6));
        tbl.push_back(mk_app(8, 8, 0, 6));
        tbl.push_back(mk_srch(5, 6, 1, 5, 6, 6));
        tbl.push_back(mk_srch(8, 8, 0, 0, 6, 6));

        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        #1;
        chk("reset_count", int'(count), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_found", int'(rsp_found), 0);
        chk("reset_rsp_index", int'(rsp_index), 0);
        chk("reset_full", int'(full), 0);
        chk("reset_ins_ready", int'(ins_ready), 1);
        chk("reset_req_ready", int'(req_ready), 1);

        foreach (tbl[i]) begin
            if (tbl[i].is_search)
                do_search(tbl[i].x, tbl[i].y, tbl[i].exp_found, tbl[i].exp_index, tbl[i].exp_lat, 0);
            else
                do_append(tbl[i].x, tbl[i].y, tbl[i].exp_ready);
            chk("count", int'(count), tbl[i].exp_count);
        end
        chk("full_set", int'(full), 1);

        // Flush, then same-cycle append and search: append wins.
        clear = 1'b1;
        @(posedge Clk); #1;
        clear = 1'b0;
        chk("clear_count", int'(count), 0);
        chk("clear_full", int'(full), 0);
        ins_valid = 1'b1; ins_x = 3; ins_y = 3;
        req_valid = 1'b1; req_x = 3; req_y = 3;
        #1;
        chk("prio_req_ready", int'(req_ready), 0);
        chk("prio_ins_ready", int'(ins_ready), 1);
        @(posedge Clk); #1;
        ins_valid = 1'b0;
        chk("prio_count", int'(count), 1);
        do_search(3, 3, 1, 0, 1, 0);

        // Response held while consumer stalls; appends blocked.
        do_append(6, 1, 1);
        do_search(6, 1, 1, 1, 2, 5);
        chk("after_hold_count", int'(count), 2);

        // clear mid-scan aborts without a response.
        do_append(1, 2, 1);
        do_append(3, 4, 1);
        req_valid = 1'b1; req_x = 9; req_y = 9;
        @(posedge Clk); #1;
        req_valid = 1'b0;
        @(posedge Clk); #1;
        chk("scan_busy", int'(busy), 1);
        clear = 1'b1;
        @(posedge Clk); #1;
        clear = 1'b0;
        chk("midclear_busy", int'(busy), 0);
        chk("midclear_count", int'(count), 0);
        chk("midclear_rsp_valid", int'(rsp_valid), 0);
        repeat (5) begin
            @(posedge Clk); #1;
            chk("midclear_no_rsp", int'(rsp_valid), 0);
        end

        // Async Reset mid-scan, after a hit has left found/index nonzero.
        do_append(1, 2, 1);
        do_append(3, 4, 1);
        do_append(5, 6, 1);
        do_search(5, 6, 1, 2, 3, 0);
        req_valid = 1'b1; req_x = 8; req_y = 8;
        @(posedge Clk); #1;
        req_valid = 1'b0;
        @(posedge Clk); #2;
        chk("prereset_busy", int'(busy), 1);
        Reset = 1'b1;
        #1;
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_count", int'(count), 0);
        chk("midreset_rsp_valid", int'(rsp_valid), 0);
        chk("midreset_rsp_found", int'(rsp_found), 0);
        chk("midreset_rsp_index", int'(rsp_index), 0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        repeat (4) begin
            @(posedge Clk); #1;
            chk("postreset_no_rsp", int'(rsp_valid), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
